// File: rtl/nemu_packet_stats.sv
// nemu_packet_stats: per-node packet count and latency statistics for a network model.
// Each node keeps a saturating packet count and latency sum, plus optional min/max latency.
// Statistics accumulate only while a measurement window is open. A registered readout
// port returns one statistic per request.
// Optional feature: define NEMU_LATENCY_MINMAX_EN to build the per-node min/max latency
// registers. Without it those registers are absent and read selects 2 and 3 return 0.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no window open, statistics frozen, waiting for i_measure
// MEASURE  | window open, valid arrivals update per-node statistics
// HOLD     | window closed, results frozen for readout until clear or re-measure

module nemu_packet_stats #(
    parameter int PORTS = 8,
    parameter int CNT_W = 16,
    parameter int LAT_W = 32,
    parameter int TS_W  = 32,
    localparam int SRC_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                   i_clk,
    input  logic                   reset_n,
    input  logic [PORTS-1:0]       i_rx_valid,
    input  logic [PORTS*SRC_W-1:0] i_rx_source,
    input  logic [PORTS*SRC_W-1:0] i_rx_dest,
    input  logic [PORTS*TS_W-1:0]  i_rx_ts,
    input  logic [TS_W-1:0]        i_timestamp,
    input  logic                   i_measure,
    input  logic                   i_clear,
    input  logic                   i_rd_en,
    input  logic [SRC_W-1:0]       i_rd_port,
    input  logic [1:0]             i_rd_sel,
    output logic                   o_rd_valid,
    output logic [LAT_W-1:0]       o_rd_data,
    output logic [1:0]             o_state,
    output logic [31:0]            o_total_pkt_count,
    output logic [PORTS-1:0]       o_dest_error,
    output logic [PORTS-1:0]       o_sat
);

    // One extra bit so a latency add that overflows the accumulator is visible.
    localparam int SUM_W = ((LAT_W > TS_W) ? LAT_W : TS_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   meas_en;

    logic [CNT_W-1:0] cnt_q   [PORTS];
    logic [LAT_W-1:0] sum_q   [PORTS];
    logic [TS_W-1:0]  lat     [PORTS];
    logic [SUM_W-1:0] sum_ext [PORTS];
    logic [SRC_W-1:0] dest    [PORTS];
    logic [PORTS-1:0] sat_q;
    logic [PORTS-1:0] derr_q;
    logic [31:0]      total_q;
    logic [31:0]      rx_pop;
    logic [LAT_W-1:0] rd_mux;
    logic             rd_valid_q;
    logic [LAT_W-1:0] rd_data_q;

    // The source field carries no statistic of its own; it is only reduced to keep it sunk.
    logic unused_src;
    assign unused_src = ^i_rx_source;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear only matters for the state while holding results.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_measure) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (!i_measure) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (i_clear)        state_d = ST_IDLE;
                else if (i_measure) state_d = ST_MEASURE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        o_state = state_q;
        meas_en = (state_q == ST_MEASURE);
    end

    // Per-node sample latency (wraps with the timestamp), widened sum and dest field.
    always_comb begin
        for (int k = 0; k < PORTS; k++) begin
            lat[k]     = i_timestamp - i_rx_ts[k*TS_W +: TS_W];
            sum_ext[k] = SUM_W'(sum_q[k]) + SUM_W'(lat[k]);
            dest[k]    = i_rx_dest[k*SRC_W +: SRC_W];
        end
    end

    // Per-node count, latency sum and sticky flags; clear beats a same-cycle arrival.
    always_ff @(posedge i_clk) begin
        if (!reset_n || i_clear) begin
            for (int k = 0; k < PORTS; k++) begin
                cnt_q[k] <= '0;
                sum_q[k] <= '0;
            end
            sat_q  <= '0;
            derr_q <= '0;
        end else if (meas_en) begin
            for (int k = 0; k < PORTS; k++) begin
                if (i_rx_valid[k]) begin
                    if (cnt_q[k] == CNT_MAX) begin
                        sat_q[k] <= 1'b1;
                    end else begin
                        cnt_q[k] <= cnt_q[k] + 1'b1;
                    end
                    if (sum_ext[k] > SUM_W'(LAT_MAX)) begin
                        sum_q[k] <= LAT_MAX;
                        sat_q[k] <= 1'b1;
                    end else begin
                        sum_q[k] <= sum_ext[k][LAT_W-1:0];
                    end
                    if (dest[k] != SRC_W'(k)) begin
                        derr_q[k] <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef NEMU_LATENCY_MINMAX_EN
    logic [TS_W-1:0] min_q [PORTS];
    logic [TS_W-1:0] max_q [PORTS];

    // Per-node min/max latency; min restarts at all-ones so the first sample always lands.
    always_ff @(posedge i_clk) begin
        if (!reset_n || i_clear) begin
            for (int k = 0; k < PORTS; k++) begin
                min_q[k] <= '1;
                max_q[k] <= '0;
            end
        end else if (meas_en) begin
            for (int k = 0; k < PORTS; k++) begin
                if (i_rx_valid[k]) begin
                    if (lat[k] < min_q[k]) min_q[k] <= lat[k];
                    if (lat[k] > max_q[k]) max_q[k] <= lat[k];
                end
            end
        end
    end
`endif

    // Population count of this cycle's arrivals.
    always_comb begin
        rx_pop = '0;
        for (int k = 0; k < PORTS; k++) begin
            rx_pop = rx_pop + 32'(i_rx_valid[k]);
        end
    end

    // Free-running arrival total, counted in every state and untouched by clear.
    always_ff @(posedge i_clk) begin
        if (!reset_n) begin
            total_q <= '0;
        end else begin
            total_q <= total_q + rx_pop;
        end
    end

    // Readout select from the registered statistics; out-of-range nodes read 0.
    always_comb begin
        rd_mux = '0;
        if (32'(i_rd_port) < 32'(PORTS)) begin
            case (i_rd_sel)
                2'd0:    rd_mux = LAT_W'(cnt_q[i_rd_port]);
                2'd1:    rd_mux = sum_q[i_rd_port];
`ifdef NEMU_LATENCY_MINMAX_EN
                2'd2:    rd_mux = LAT_W'(min_q[i_rd_port]);
                2'd3:    rd_mux = LAT_W'(max_q[i_rd_port]);
`endif
                default: rd_mux = '0;
            endcase
        end
    end

    // Readout response register; data holds between requests.
    always_ff @(posedge i_clk) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= i_rd_en;
            if (i_rd_en) rd_data_q <= rd_mux;
        end
    end

    assign o_rd_valid        = rd_valid_q;
    assign o_rd_data         = rd_data_q;
    assign o_total_pkt_count = total_q;
    assign o_dest_error      = derr_q;
    assign o_sat             = sat_q;

endmodule

// File: doc/nemu_packet_stats.md
NEMU_PACKET_STATS -- requirements
Module: nemu_packet_stats

Interface
REQ-001 Parameters SHALL be: PORTS, default 8, number of network nodes; CNT_W, default 16, packet counter width; LAT_W, default 32, latency accumulator width; TS_W, default 32, timestamp width.
REQ-002 SRC_W SHALL be the derived localparam $clog2(PORTS), with a minimum of 1.
REQ-003 Port i_clk, in, 1: the single clock; all logic is on the rising edge.
REQ-004 Port reset_n, in, 1: synchronous active-low reset.
REQ-005 Port i_rx_valid, in, PORTS: packet arriving at node k this cycle.
REQ-006 Port i_rx_source, in, PORTS*SRC_W: source field of the packet at node k, slice k.
REQ-007 Port i_rx_dest, in, PORTS*SRC_W: dest field of the packet at node k, slice k.
REQ-008 Port i_rx_ts, in, PORTS*TS_W: injection timestamp carried in the packet, slice k.
REQ-009 Port i_timestamp, in, TS_W: free-running network time.
REQ-010 Port i_measure, in, 1: measurement window request.
REQ-011 Port i_clear, in, 1: clear all statistics.
REQ-012 Ports i_rd_en (in, 1), i_rd_port (in, SRC_W) and i_rd_sel (in, 2) form the readout request.
REQ-013 Ports o_rd_valid (out, 1) and o_rd_data (out, LAT_W) form the readout response.
REQ-014 Port o_state, out, 2: FSM state; IDLE=0, MEASURE=1, HOLD=2.
REQ-015 Port o_total_pkt_count, out, 32: all valid packets received, measured or not.
REQ-016 Port o_dest_error, out, PORTS: sticky flag; a packet arrived at node k with dest != k.
REQ-017 Port o_sat, out, PORTS: sticky flag; a counter or accumulator of node k saturated.

Function
REQ-018 Per node k the block SHALL keep cnt[k] (CNT_W), lat_sum[k] (LAT_W), lat_min[k] (TS_W) and lat_max[k] (TS_W).
REQ-019 Sample latency SHALL be (i_timestamp - ts) modulo 2^TS_W, so timestamp wrap-around yields the correct value.
REQ-020 In MEASURE, a valid packet at node k SHALL give cnt[k]+1, lat_sum[k]+latency, a min/max update, and a dest check, all in one cycle.
REQ-021 All PORTS nodes SHALL update independently in the same cycle; no arrival is dropped.
REQ-022 cnt and lat_sum SHALL saturate at all-ones; the first clamp sets o_sat[k].
REQ-023 o_total_pkt_count SHALL increment by popcount(i_rx_valid) every cycle in every state, wrapping at 2^32.
REQ-024 FSM transitions SHALL be: IDLE->MEASURE when i_measure=1; MEASURE->HOLD when i_measure=0; HOLD->IDLE when i_clear=1; HOLD->MEASURE when i_measure=1 and i_clear=0, with statistics kept and accumulated.
REQ-025 In IDLE and HOLD the per-node statistics SHALL be frozen.
REQ-026 i_clear SHALL zero cnt, lat_sum, lat_max, o_sat and o_dest_error, and set lat_min to all-ones, in any state; o_total_pkt_count is not cleared.
REQ-027 If i_clear and a valid packet occur in the same cycle, clear SHALL win and that packet is not accumulated.
REQ-028 In MEASURE, i_clear SHALL NOT change state.
REQ-029 Readout: with i_rd_en=1 at cycle N, the block SHALL assert o_rd_valid=1 at cycle N+1 with data for node i_rd_port.
REQ-030 Read select SHALL be: sel 0=cnt, 1=lat_sum, 2=lat_min, 3=lat_max; each is zero-extended to LAT_W.
REQ-031 Readout SHALL be allowed in any state and SHALL return the registered value before any same-cycle update.
REQ-032 i_rd_port >= PORTS SHALL return 0 with o_rd_valid=1.

Reset
REQ-033 reset_n=0 at a rising edge SHALL give o_state=IDLE, all counters and accumulators and flags 0, lat_min all-ones, o_rd_valid=0, o_rd_data=0, o_total_pkt_count=0.
REQ-034 Reset SHALL take priority over clear, measure and readout, including when asserted mid-window.

Configuration
REQ-035 With macro NEMU_LATENCY_MINMAX_EN defined, lat_min and lat_max SHALL be implemented as in REQ-018 to REQ-030.
REQ-036 Without NEMU_LATENCY_MINMAX_EN, the min/max registers SHALL be absent and sel 2 and sel 3 SHALL read 0.

Verification
REQ-037 Reset, then i_measure=1; node 2 gets 3 packets with i_timestamp-ts = 5, 9, 7. Reading node 2 SHALL return cnt=3, lat_sum=21, min=5, max=9.
REQ-038 TS_W=32, ts=0xFFFFFFFE, i_timestamp=0x00000003. The sample SHALL be 5.
REQ-039 All 8 nodes valid for 10 cycles in IDLE. o_total_pkt_count SHALL be 80, every cnt=0, o_state=0.
REQ-040 CNT_W=4, 17 packets to node 0 in MEASURE. cnt[0] SHALL be 15 and o_sat[0]=1.
REQ-041 Packet at node 1 with dest=3, then drop i_measure. o_dest_error[1]=1, o_state=2; i_clear SHALL set o_state=0 and o_dest_error=0.
REQ-042 i_clear together with a valid packet at node 4 in MEASURE. cnt[4] SHALL be 0, lat_min[4]=0xFFFFFFFF, o_state=1.
